// File: rtl/fft_stage_sched.sv
// rtl/fft_stage_sched.sv - radix-2 in-place FFT stage scheduler: butterfly read/write addresses and twiddle index
// Define FFT_STAGE_SCHED_PERF_EN to add the o_cycle_cnt busy-cycle counter.
module fft_stage_sched #(
  parameter int LOG2N    = 3,
  parameter int BFLY_LAT = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_rd_en,
  output logic [LOG2N-1:0]         o_rd_addr_a,
  output logic [LOG2N-1:0]         o_rd_addr_b,
  output logic                     o_wr_en,
  output logic [LOG2N-1:0]         o_wr_addr_a,
  output logic [LOG2N-1:0]         o_wr_addr_b,
  output logic [LOG2N-2:0]         o_tw_idx,
`ifdef FFT_STAGE_SCHED_PERF_EN
  output logic [15:0]              o_cycle_cnt,
`endif
  output logic [$clog2(LOG2N)-1:0] o_stage
);

  localparam int AW = LOG2N;
  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = 4;
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [DW-1:0] D_LAST = DW'(BFLY_LAT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [AW-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, span_d;
  logic [KW-1:0] tw_q, tw_d, idx_d;

  logic          wr_en_pipe_q [BFLY_LAT];
  logic [AW-1:0] wr_a_pipe_q  [BFLY_LAT];
  logic [AW-1:0] wr_b_pipe_q  [BFLY_LAT];

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = ISSUE;
        stage_d = '0;
        k_d     = '0;
      end
      ISSUE: if (k_q == K_LAST) begin
        state_d = DRAIN;
        dcnt_d  = '0;
      end else begin
        k_d = k_q + KW'(1);
      end
      DRAIN: if (dcnt_q == D_LAST) begin
        if (stage_q == S_LAST) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
          stage_d = stage_q + SW'(1);
          k_d     = '0;
        end
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so that they are registered yet aligned with the state.
    busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == ISSUE);
    span_d  = AW'(1) << stage_d;
    idx_d   = k_d & KW'(span_d - AW'(1));
    rd_a_d  = '0;
    rd_b_d  = '0;
    tw_d    = '0;
    if (rd_en_d) begin
      rd_a_d = (((AW'(k_d) >> stage_d) << stage_d) << 1) | AW'(idx_d);
      rd_b_d = rd_a_d + span_d;
      tw_d   = idx_d << (S_LAST - stage_d);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
    end
  end

  // Write-back delay line; reset drops every in-flight butterfly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BFLY_LAT; i++) begin
        wr_en_pipe_q[i] <= 1'b0;
        wr_a_pipe_q[i]  <= '0;
        wr_b_pipe_q[i]  <= '0;
      end
    end else begin
      wr_en_pipe_q[0] <= rd_en_q;
      wr_a_pipe_q[0]  <= rd_a_q;
      wr_b_pipe_q[0]  <= rd_b_q;
      for (int i = 1; i < BFLY_LAT; i++) begin
        wr_en_pipe_q[i] <= wr_en_pipe_q[i-1];
        wr_a_pipe_q[i]  <= wr_a_pipe_q[i-1];
        wr_b_pipe_q[i]  <= wr_b_pipe_q[i-1];
      end
    end
  end

`ifdef FFT_STAGE_SCHED_PERF_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) && i_start) begin
      cnt_d = '0;
    end else if (busy_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cycle_cnt = cnt_q;
`endif

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rd_en     = rd_en_q;
  assign o_rd_addr_a = rd_a_q;
  assign o_rd_addr_b = rd_b_q;
  assign o_tw_idx    = tw_q;
  assign o_stage     = stage_q;
  assign o_wr_en     = wr_en_pipe_q[BFLY_LAT-1];
  assign o_wr_addr_a = wr_a_pipe_q[BFLY_LAT-1];
  assign o_wr_addr_b = wr_b_pipe_q[BFLY_LAT-1];

endmodule

// File: doc/fft_stage_sched.md
FFT_STAGE_SCHED -- requirements
Module: fft_stage_sched

Interface
REQ-001 SHALL have parameter LOG2N, default 3, meaning log2 of FFT size N; legal range 2..10.
REQ-002 SHALL have parameter BFLY_LAT, default 3, meaning cycles from read issue to write-back (1 memory read plus 2 butterfly register stages); legal range 1..8.
REQ-003 SHALL have port i_clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  request to run a full in-place radix-2 FFT pass set.
REQ-006 SHALL have port o_busy  output  1  high while stages are being issued or drained.
REQ-007 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port o_rd_en  output  1  sample-memory read strobe for one butterfly pair.
REQ-009 SHALL have ports o_rd_addr_a and o_rd_addr_b  output  LOG2N  read addresses of the pair.
REQ-010 SHALL have port o_wr_en  output  1  write-back strobe for the butterfly results.
REQ-011 SHALL have ports o_wr_addr_a and o_wr_addr_b  output  LOG2N  write addresses for o_a and o_b.
REQ-012 SHALL have port o_tw_idx  output  LOG2N-1  twiddle ROM index aligned with o_rd_en.
REQ-013 SHALL have port o_stage  output  ceil(log2(LOG2N))  current stage number.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, DRAIN and DONE, with every output registered.
REQ-015 In IDLE, i_start=1 SHALL move the FSM to ISSUE on the next cycle with stage=0 and k=0; i_start SHALL be ignored in all other states.
REQ-016 In ISSUE, o_rd_en SHALL be 1 every cycle, and k SHALL increment from 0 to N/2-1.
REQ-017 After k=N/2-1, ISSUE SHALL move to DRAIN.
REQ-018 Address generation SHALL use span=2^stage and idx=k mod span.
REQ-019 o_rd_addr_a SHALL equal ((k>>stage)<<(stage+1)) | idx.
REQ-020 o_rd_addr_b SHALL equal o_rd_addr_a + span.
REQ-021 o_tw_idx SHALL equal idx<<(LOG2N-1-stage).
REQ-022 o_wr_en, o_wr_addr_a and o_wr_addr_b SHALL be copies of o_rd_en, o_rd_addr_a and o_rd_addr_b delayed by exactly BFLY_LAT cycles through a shift pipeline.
REQ-023 DRAIN SHALL last exactly BFLY_LAT cycles, so the last write of a stage lands before the first read of the next stage.
REQ-024 At the end of DRAIN, if stage<LOG2N-1 the FSM SHALL increment stage, clear k and return to ISSUE; otherwise it SHALL go to DONE.
REQ-025 DONE SHALL last one cycle, assert o_done=1 for that cycle, and then return to IDLE.
REQ-026 o_busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and DONE.
REQ-027 o_rd_en SHALL be 0 outside ISSUE.
REQ-028 The total run SHALL take LOG2N*(N/2+BFLY_LAT) cycles from the first ISSUE cycle to the DONE cycle, exclusive of the DONE cycle.
REQ-029 A back-to-back i_start presented in the DONE cycle SHALL be ignored; the start is accepted only in IDLE.

Reset
REQ-030 i_rst=1 SHALL force state IDLE, stage=0, k=0, and clear all delay-pipeline valid bits.
REQ-031 While i_rst=1, all outputs SHALL be 0 on the following cycle.
REQ-032 A reset mid-operation SHALL discard in-flight writes, so o_wr_en=0 from the cycle after reset is sampled.
REQ-033 After reset is released, no o_done pulse SHALL be generated for the aborted run.

Configuration
REQ-034 With macro FFT_STAGE_SCHED_PERF_EN defined, the block SHALL add output o_cycle_cnt (16 bits).
REQ-035 With FFT_STAGE_SCHED_PERF_EN defined, o_cycle_cnt SHALL clear on an accepted start and increment every busy cycle, saturating at 0xFFFF.
REQ-036 With FFT_STAGE_SCHED_PERF_EN defined, o_cycle_cnt SHALL hold its value after DONE until the next accepted start, and SHALL reset to 0.
REQ-037 Without FFT_STAGE_SCHED_PERF_EN, the port and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 With LOG2N=3, BFLY_LAT=3, and i_start pulsed at cycle 0, the bench SHALL see: stage0 reads (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0 in cycles 1-4; stage1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2 in cycles 8-11; stage2 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3 in cycles 15-18.
REQ-039 In the same run, o_wr_en SHALL be high in cycles 4-7, 11-14 and 18-21 with addresses matching the reads, and o_done SHALL be high only in cycle 22.
REQ-040 With i_start held high continuously, runs SHALL restart only from IDLE, with no overlap; the second run's first read SHALL occur 2 cycles after the first o_done.
REQ-041 Asserting i_rst in cycle 10 SHALL give o_busy=0, o_rd_en=0 and o_wr_en=0 from cycle 11, and no o_done afterwards.
REQ-042 With FFT_STAGE_SCHED_PERF_EN defined, LOG2N=3 and BFLY_LAT=3, o_cycle_cnt SHALL read 21 after o_done and stay at 21 until the next start.
REQ-043 With LOG2N=2 and BFLY_LAT=1, the bench SHALL see stage0 (0,1),(2,3) and stage1 (0,2),(1,3), with o_done 7 cycles after start.
